// File: rtl/vga_timing.sv
// 640x480@60 VGA timing generator: free-running h/v counters, combinational
// visible-position outputs, and one registered stage for sync, colour and frame_start.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic        CLOCK_25,
    input  logic        reset_n,
    input  logic [2:0]  color,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        active,
    output logic        frame_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       vga_hs_q, vga_hs_d;
    logic       vga_vs_q, vga_vs_d;
    logic [3:0] vga_r_q, vga_r_d;
    logic [3:0] vga_g_q, vga_g_d;
    logic [3:0] vga_b_q, vga_b_d;
    logic       frame_start_q, frame_start_d;
    logic       h_wrap;

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end

        active = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        x      = active ? {2'b00, h_cnt_q} + 12'd1 : 12'd0;
        y      = active ? {2'b00, v_cnt_q} + 12'd1 : 12'd0;

        // Sync and colour share the same register stage so they stay aligned.
        vga_hs_d      = !((h_cnt_q >= H_SS) && (h_cnt_q <= H_SE));
        vga_vs_d      = !((v_cnt_q >= V_SS) && (v_cnt_q <= V_SE));
        vga_r_d       = active ? {4{color[2]}} : 4'h0;
        vga_g_d       = active ? {4{color[1]}} : 4'h0;
        vga_b_d       = active ? {4{color[0]}} : 4'h0;
        frame_start_d = h_wrap && (v_cnt_q == V_LAST);
    end

    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            vga_r_q       <= 4'h0;
            vga_g_q       <= 4'h0;
            vga_b_q       <= 4'h0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            vga_r_q       <= vga_r_d;
            vga_g_q       <= vga_g_d;
            vga_b_q       <= vga_b_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default-timing instance plus a short-frame instance
// (reduced vertical totals) so whole frames fit in a short run.
module tb_vga_timing;

    localparam int VB_ACT = 8, VB_FR = 2, VB_SY = 2, VB_BK = 3;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        act;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
    } obs_t;

    typedef struct {
        int          n;
        logic [11:0] x;
        logic [11:0] y;
        logic        act;
        logic        hs;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] color = 3'b000;

    logic [11:0] xa, ya, xb, yb;
    logic acta, fsa, hsa, vsa, actb, fsb, hsb, vsb;
    logic [3:0] ra, ga, ba, rb, gb, bb;

    vga_timing dut_a (
        .CLOCK_25(clk), .reset_n(rst_n), .color(color),
        .x(xa), .y(ya), .active(acta), .frame_start(fsa),
        .vga_hs(hsa), .vga_vs(vsa), .vga_r(ra), .vga_g(ga), .vga_b(ba)
    );

    vga_timing #(.V_ACTIVE(VB_ACT), .V_FRONT(VB_FR), .V_SYNC(VB_SY), .V_BACK(VB_BK)) dut_b (
        .CLOCK_25(clk), .reset_n(rst_n), .color(color),
        .x(xb), .y(yb), .active(actb), .frame_start(fsb),
        .vga_hs(hsb), .vga_vs(vsb), .vga_r(rb), .vga_g(gb), .vga_b(bb)
    );

    always #20 clk = ~clk;

    obs_t obs_a, obs_b;
    assign obs_a = {xa, ya, acta, fsa, hsa, vsa, ra, ga, ba};
    assign obs_b = {xb, yb, actb, fsb, hsb, vsb, rb, gb, bb};

    int n;              // rising edges since reset release
    logic [2:0] pc;     // colour present at the most recent edge
    int checks = 0;
    int passed = 0;
    vec_t tab[11];

    // Reference: position from elapsed clocks, registered outputs from the previous position.
    function automatic obs_t model(int k, int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb, logic [2:0] c);
        obs_t o;
        int ht, vt, h, v, hp, vp;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        h  = k % ht;
        v  = (k / ht) % vt;
        o  = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        if (h < ha && v < va) begin
            o.act = 1'b1;
            o.x   = 12'(h + 1);
            o.y   = 12'(v + 1);
        end
        if (k > 0) begin
            hp   = (k - 1) % ht;
            vp   = ((k - 1) / ht) % vt;
            o.hs = !(hp >= ha + hf && hp < ha + hf + hsw);
            o.vs = !(vp >= va + vf && vp < va + vf + vsw);
            o.fs = (k % (ht * vt)) == 0;
            if (hp < ha && vp < va) begin
                o.r = {4{c[2]}};
                o.g = {4{c[1]}};
                o.b = {4{c[0]}};
            end
        end
        return o;
    endfunction

    task automatic check(string name, logic [39:0] got, logic [39:0] req);
        checks++;
        if (got === req) passed++;
        else $display("FAIL %s: got %0h required %0h", name, got, req);
    endtask

    task automatic tick();
        pc = color;
        @(posedge clk);
        if (rst_n) n++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
    endtask

    initial begin
        int hlow, hfirst, on, off;
        int sb_a, sb_b, run, last_run, last_fall, period, fs_cnt, fs_first, fsa_cnt;
        logic prev_vsb;
        string first_a, first_b;
        obs_t ma, mb;

        tab[0]  = '{0,   12'd1,   12'd1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        tab[1]  = '{1,   12'd2,   12'd1, 1'b1, 1'b1, 4'hF, 4'h0, 4'hF};
        tab[2]  = '{639, 12'd640, 12'd1, 1'b1, 1'b1, 4'hF, 4'h0, 4'hF};
        tab[3]  = '{640, 12'd0,   12'd0, 1'b0, 1'b1, 4'hF, 4'h0, 4'hF};
        tab[4]  = '{641, 12'd0,   12'd0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
        tab[5]  = '{656, 12'd0,   12'd0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
        tab[6]  = '{657, 12'd0,   12'd0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
        tab[7]  = '{752, 12'd0,   12'd0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
        tab[8]  = '{753, 12'd0,   12'd0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
        tab[9]  = '{800, 12'd1,   12'd2, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        tab[10] = '{801, 12'd2,   12'd2, 1'b1, 1'b1, 4'hF, 4'h0, 4'hF};

        // Reset held across clock edges.
        n = 0;
        pc = 3'b000;
        color = 3'b101;
        @(negedge clk);
        @(negedge clk);
        check("reset_a", 40'(obs_a), 40'({12'd1, 12'd1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000}));
        check("reset_b", 40'(obs_b), 40'({12'd1, 12'd1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000}));

        // Directed vectors along the first lines, colour 101.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            while (n < tab[i].n) tick();
            check($sformatf("vec_n%0d", tab[i].n),
                  40'({xa, ya, acta, hsa, ra, ga, ba}),
                  40'({tab[i].x, tab[i].y, tab[i].act, tab[i].hs, tab[i].r, tab[i].g, tab[i].b}));
        end

        // One full line: hsync position/width and colour on/off counts.
        do_reset();
        hlow = 0; hfirst = -1; on = 0; off = 0;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (!hsa) begin
                hlow++;
                if (hfirst < 0) hfirst = n;
            end
            if ({ra, ga, ba} == 12'hF0F) on++;
            else if ({ra, ga, ba} == 12'h000) off++;
        end
        check("hs_fall_edge", 40'(hfirst), 40'd657);
        check("hs_width", 40'(hlow), 40'd96);
        check("rgb_on_count", 40'(on), 40'd640);
        check("rgb_off_count", 40'(off), 40'd160);

        // Random colour, scoreboard against the model, two short frames on instance b.
        do_reset();
        sb_a = 0; sb_b = 0; run = 0; last_run = -1; last_fall = -1; period = -1;
        fs_cnt = 0; fs_first = -1; fsa_cnt = 0; prev_vsb = 1'b1;
        first_a = ""; first_b = "";
        for (int i = 0; i < 25000; i++) begin
            color = 3'($urandom);
            tick();
            ma = model(n, 640, 16, 96, 48, 480, 10, 2, 33, pc);
            mb = model(n, 640, 16, 96, 48, VB_ACT, VB_FR, VB_SY, VB_BK, pc);
            if (obs_a !== ma) begin
                sb_a++;
                if (first_a == "") first_a = $sformatf("a n=%0d got %h want %h", n, obs_a, ma);
            end
            if (obs_b !== mb) begin
                sb_b++;
                if (first_b == "") first_b = $sformatf("b n=%0d got %h want %h", n, obs_b, mb);
            end
            if (!vsb) run++;
            if (prev_vsb && !vsb) begin
                if (last_fall >= 0) period = n - last_fall;
                last_fall = n;
            end
            if (!prev_vsb && vsb) begin
                last_run = run;
                run = 0;
            end
            prev_vsb = vsb;
            if (fsb) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = n;
            end
            if (fsa) fsa_cnt++;
            case (n)
                5600:  check("b_last_row_y", 40'({yb, actb}), 40'({12'd8, 1'b1}));
                6239:  check("b_last_px", 40'({xb, yb}), 40'({12'd640, 12'd8}));
                6400:  check("b_below_active", 40'({xb, yb, actb}), 40'({12'd0, 12'd0, 1'b0}));
                11999: check("b_pre_wrap_fs", 40'(fsb), 40'd0);
                12000: check("b_wrap", 40'({xb, yb, actb, fsb}), 40'({12'd1, 12'd1, 1'b1, 1'b1}));
                12001: check("b_fs_single", 40'({xb, fsb}), 40'({12'd2, 1'b0}));
                default: ;
            endcase
        end
        if (sb_a != 0) $display("  first diff %s", first_a);
        if (sb_b != 0) $display("  first diff %s", first_b);
        check("scoreboard_a", 40'(sb_a), 40'd0);
        check("scoreboard_b", 40'(sb_b), 40'd0);
        check("b_vs_width", 40'(last_run), 40'd1600);
        check("b_vs_period", 40'(period), 40'd12000);
        check("b_fs_count", 40'(fs_cnt), 40'd2);
        check("b_fs_first", 40'(fs_first), 40'd12000);
        check("a_fs_none", 40'(fsa_cnt), 40'd0);

        // Reset asserted inside hsync clears outputs without a clock edge.
        color = 3'b111;
        do_reset();
        while (n < 700) tick();
        check("hs_low_at_700", 40'(hsa), 40'd0);
        rst_n = 1'b0;
        #1;
        check("rst_async", 40'({hsa, vsa, fsa, ra, ga, ba, xa, ya, acta}),
              40'({1'b1, 1'b1, 1'b0, 12'h000, 12'd1, 12'd1, 1'b1}));
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        check("restart_xy", 40'({xa, ya, hsa}), 40'({12'd1, 12'd1, 1'b1}));
        tick();
        check("restart_step", 40'(obs_a), 40'(model(n, 640, 16, 96, 48, 480, 10, 2, 33, pc)));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
